// File: rtl/hc_sr04_pkg.sv
// rtl/hc_sr04_pkg.sv - shared state encoding and result codes for the HC-SR04 scheduler
package hc_sr04_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PICK    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_HOLDOFF = 3'd4
  } sched_state_e;

  // Distance reported when the engine never answers; sliced down to the result width.
  localparam logic [63:0] TIMEOUT_CODE = '1;

endpackage

// File: rtl/rr_next_index.sv
// rtl/rr_next_index.sv - combinational round-robin search for the next set mask bit
// Returns cur_i unchanged when the mask is empty.
module rr_next_index #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] cur_i,
  output logic [IW-1:0] next_o
);

  localparam int CW = IW + 1;

  logic [CW-1:0] cand;
  logic          found;

  always_comb begin
    next_o = cur_i;
    found  = 1'b0;
    cand   = '0;
    // k == N lands back on cur_i, so a lone set bit re-selects itself.
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, cur_i} + CW'(k);
      if (cand >= CW'(N)) begin
        cand = cand - CW'(N);
      end
      if (!found && mask_i[cand[IW-1:0]]) begin
        next_o = cand[IW-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hc_sr04_scheduler.sv
// rtl/hc_sr04_scheduler.sv - round-robin scheduler sharing one HC-SR04 measurement engine
// Optional WAIT watchdog is compiled in with HC_SR04_SCHEDULER_TIMEOUT_EN.
module hc_sr04_scheduler
  import hc_sr04_pkg::*;
#(
  parameter int N_SENSORS      = 4,
  parameter int DISTANCE_WIDTH = 12,
  parameter int HOLDOFF_CYCLES = 3000000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic [N_SENSORS-1:0]                sensor_mask,
  output logic [N_SENSORS-1:0]                trig,
  input  logic [N_SENSORS-1:0]                echo,
  output logic                                eng_start,
  input  logic                                eng_trig,
  output logic                                eng_echo,
  input  logic                                eng_done,
  input  logic [DISTANCE_WIDTH-1:0]           eng_distance,
  output logic [$clog2(N_SENSORS)-1:0]        sel,
  output logic [N_SENSORS*DISTANCE_WIDTH-1:0] distances,
  output logic [N_SENSORS-1:0]                valid,
  output logic                                result_stb,
  output logic [$clog2(N_SENSORS)-1:0]        result_idx
);

  localparam int SEL_W  = $clog2(N_SENSORS);
  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  sched_state_e                       state_q, state_d;
  logic [SEL_W-1:0]                   sel_q, sel_d;
  logic                               first_q, first_d;
  logic [HOLD_W-1:0]                  hold_q, hold_d;
  logic [N_SENSORS*DISTANCE_WIDTH-1:0] dist_q, dist_d;
  logic [N_SENSORS-1:0]               valid_q, valid_d;
  logic                               stb_q, stb_d;
  logic [SEL_W-1:0]                   idx_q, idx_d;
  logic [SEL_W-1:0]                   rr_cur, rr_next;
  logic                               timeout;

  // Before the first pick the search starts from the top index so it wraps to the lowest set bit.
  assign rr_cur = first_q ? SEL_W'(N_SENSORS - 1) : sel_q;

  rr_next_index #(
    .N  (N_SENSORS),
    .IW (SEL_W)
  ) u_rr (
    .mask_i (sensor_mask),
    .cur_i  (rr_cur),
    .next_o (rr_next)
  );

`ifdef HC_SR04_SCHEDULER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] wait_q, wait_d;

  assign wait_d  = (state_q == ST_WAIT) ? wait_q + 1'b1 : '0;
  assign timeout = (state_q == ST_WAIT) && (wait_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  // No watchdog in this build: WAIT is left only through eng_done.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      first_q <= 1'b1;
      hold_q  <= '0;
      dist_q  <= '0;
      valid_q <= '0;
      stb_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      first_q <= first_d;
      hold_q  <= hold_d;
      dist_q  <= dist_d;
      valid_q <= valid_d;
      stb_q   <= stb_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    first_d = first_q;
    hold_d  = '0;
    dist_d  = dist_q;
    valid_d = valid_q;
    stb_d   = 1'b0;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && (|sensor_mask)) begin
          state_d = ST_PICK;
        end
      end
      ST_PICK: begin
        if (|sensor_mask) begin
          sel_d   = rr_next;
          first_d = 1'b0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // enable and sensor_mask are deliberately ignored until the measurement closes.
        if (eng_done || timeout) begin
          dist_d[int'(sel_q)*DISTANCE_WIDTH +: DISTANCE_WIDTH] =
            eng_done ? eng_distance : TIMEOUT_CODE[DISTANCE_WIDTH-1:0];
          valid_d[sel_q] = 1'b1;
          stb_d          = 1'b1;
          idx_d          = sel_q;
          state_d        = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (hold_q == HOLD_W'(HOLDOFF_CYCLES - 1)) begin
          state_d = (enable && (|sensor_mask)) ? ST_PICK : ST_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    trig      = '0;
    eng_start = (state_q == ST_START);
    eng_echo  = echo[sel_q];
    if ((state_q == ST_START) || (state_q == ST_WAIT)) begin
      trig[sel_q] = eng_trig;
    end
  end

  assign sel        = sel_q;
  assign distances  = dist_q;
  assign valid      = valid_q;
  assign result_stb = stb_q;
  assign result_idx = idx_q;

endmodule

// File: tb/tb_hc_sr04_scheduler.sv
// tb/tb_hc_sr04_scheduler.sv - randomized self-checking bench with a behavioural scheduler model
module tb_hc_sr04_scheduler;

  localparam int N    = 4;
  localparam int W    = 12;
  localparam int HOLD = 20;
  localparam int TMO  = 50;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enable;
  logic [N-1:0]   sensor_mask;
  logic [N-1:0]   trig;
  logic [N-1:0]   echo;
  logic           eng_start;
  logic           eng_trig;
  logic           eng_echo;
  logic           eng_done = 1'b0;
  logic [W-1:0]   eng_distance = '0;
  logic [1:0]     sel;
  logic [N*W-1:0] distances;
  logic [N-1:0]   valid;
  logic           result_stb;
  logic [1:0]     result_idx;

  int n_checks = 0;
  int n_errors = 0;

  hc_sr04_scheduler #(
    .N_SENSORS      (N),
    .DISTANCE_WIDTH (W),
    .HOLDOFF_CYCLES (HOLD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sensor_mask  (sensor_mask),
    .trig         (trig),
    .echo         (echo),
    .eng_start    (eng_start),
    .eng_trig     (eng_trig),
    .eng_echo     (eng_echo),
    .eng_done     (eng_done),
    .eng_distance (eng_distance),
    .sel          (sel),
    .distances    (distances),
    .valid        (valid),
    .result_stb   (result_stb),
    .result_idx   (result_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int           cyc = 0;
  int           start_cnt = 0;
  int           res_cnt = 0;
  int           prev_sel = 0;
  int           cur_lat = 0;
  int           eng_cnt = -1;
  int           last_start_cyc = 0;
  int           last_res_cyc = 0;
  int           last_gap = 0;
  int           exp_sel;
  int           exp_i;
  bit           first_pick = 1'b1;
  bit           gap_known = 1'b0;
  bit           chk_gap = 1'b0;
  bit           engine_on = 1'b1;
  bit           fixed_mode = 1'b1;
  bit           kick = 1'b0;
  bit           stray = 1'b0;
  logic [W-1:0] cur_dist = '0;
  logic [W-1:0] kick_dist = '0;
  logic [W-1:0] exp_d;
  logic [N-1:0] mask_prev = '0;
  logic [N-1:0] exp_valid = '0;
  logic [W-1:0] exp_dist [N];
  logic [N*W-1:0] exp_pack;
  logic [15:0]  exp_e;
  logic [15:0]  exp_q [$];
  int           sel_hist [$];

  // Next included sensor strictly after prev, wrapping to the lowest one.
  function automatic int ref_pick(input logic [N-1:0] m, input int prev, input bit first);
    int lowest = -1;
    int after  = -1;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        if (lowest < 0) lowest = i;
        if (after < 0 && !first && i > prev) after = i;
      end
    end
    return (after >= 0) ? after : lowest;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      first_pick = 1'b1;
      prev_sel   = 0;
      exp_valid  = '0;
      for (int i = 0; i < N; i++) exp_dist[i] = '0;
      gap_known  = 1'b0;
      eng_cnt    = -1;
      eng_done   = 1'b0;
    end else begin
      if (!enable) gap_known = 1'b0;
      if (result_stb) begin
        if (exp_q.size() > 0) exp_e = exp_q.pop_front();
        else exp_e = {4'(prev_sel), 12'hFFF};
        exp_i = int'(exp_e[15:12]);
        exp_d = exp_e[11:0];
        exp_dist[exp_i]  = exp_d;
        exp_valid[exp_i] = 1'b1;
        for (int i = 0; i < N; i++) exp_pack[i*W +: W] = exp_dist[i];
        check("result_idx", 64'(result_idx), 64'(exp_i));
        check("distances", 64'(distances), 64'(exp_pack));
        check("valid", 64'(valid), 64'(exp_valid));
        res_cnt++;
        last_res_cyc = cyc;
      end
      if (eng_start) begin
        exp_sel = ref_pick(mask_prev, prev_sel, first_pick);
        check("pick_sel", 64'(sel), 64'(exp_sel));
        last_gap = cyc - last_start_cyc;
        if (gap_known && chk_gap) check("start_gap", 64'(last_gap), 64'(2 + HOLD + cur_lat));
        last_start_cyc = cyc;
        gap_known  = 1'b1;
        prev_sel   = exp_sel;
        first_pick = 1'b0;
        sel_hist.push_back(exp_sel);
        start_cnt++;
      end
      eng_done = 1'b0;
      if (eng_start && engine_on) begin
        cur_lat  = fixed_mode ? 10 : int'($urandom_range(15, 1));
        cur_dist = fixed_mode ? (12'h100 + 12'(prev_sel)) : 12'($urandom_range(12'hFFE, 0));
        eng_cnt  = cur_lat;
      end else if (eng_cnt >= 0) begin
        eng_cnt--;
      end
      if (engine_on && eng_cnt == 0) begin
        eng_done     = 1'b1;
        eng_distance = cur_dist;
        exp_q.push_back({4'(prev_sel), cur_dist});
      end
      if (kick) begin
        eng_done     = 1'b1;
        eng_distance = kick_dist;
        exp_q.push_back({4'(prev_sel), kick_dist});
        kick = 1'b0;
      end
      if (stray) begin
        eng_done     = 1'b1;
        eng_distance = 12'h0AA;
        stray = 1'b0;
      end
    end
    mask_prev = sensor_mask;
  end

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (start_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("wait_start_budget", 64'(start_cnt >= target), 64'd1);
  endtask

  task automatic wait_results(input int target, input int budget);
    int n = 0;
    while (res_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("wait_result_budget", 64'(res_cnt >= target), 64'd1);
  endtask

  int exp_seq [4] = '{0, 1, 3, 0};
  int saved_res;
  int saved_start;

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    sensor_mask = '0;
    echo        = '0;
    eng_trig    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_trig", 64'(trig), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_distances", 64'(distances), 64'd0);
    check("rst_eng_start", 64'(eng_start), 64'd0);
    check("rst_result_stb", 64'(result_stb), 64'd0);
    check("rst_result_idx", 64'(result_idx), 64'd0);
    check("rst_sel", 64'(sel), 64'd0);

    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_empty_mask", 64'(start_cnt), 64'd0);

    sensor_mask = 4'b1011;
    chk_gap     = 1'b1;
    wait_starts(4, 300);
    for (int i = 0; i < 4; i++) check("seq_1011", 64'(sel_hist[i]), 64'(exp_seq[i]));
    check("gap_1011", 64'(last_gap), 64'd32);
    check("dist3_1011", 64'(distances[3*W +: W]), 64'h103);

    wait_starts(5, 100);
    check("route_sel", 64'(sel), 64'd1);
    eng_trig = 1'b1;
    #1 check("route_trig", 64'(trig), 64'b0010);
    echo = 4'b0010;
    #1 check("route_echo_hit", 64'(eng_echo), 64'd1);
    echo = 4'b0100;
    #1 check("route_echo_miss", 64'(eng_echo), 64'd0);
    eng_trig = 1'b0;
    echo     = '0;

    fixed_mode = 1'b0;
    for (int r = 0; r < 16; r++) begin
      wait_starts(start_cnt + 1, 100);
      if (r >= 8 && r < 11) sensor_mask = 4'b0100;
      else if (r % 4 == 3) sensor_mask = 4'(1 << $urandom_range(3, 0));
      else sensor_mask = 4'($urandom_range(15, 1));
    end

    wait_results(res_cnt + 1, 100);
    saved_res = res_cnt;
    stray = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("stray_done_ignored", 64'(res_cnt), 64'(saved_res));

    fixed_mode = 1'b1;
    wait_starts(start_cnt + 1, 100);
    repeat (2) @(posedge clk);
    #1;
    enable      = 1'b0;
    saved_res   = res_cnt;
    saved_start = start_cnt;
    wait_results(saved_res + 1, 50);
    repeat (100) @(posedge clk);
    #1;
    check("disable_no_restart", 64'(start_cnt), 64'(saved_start));

    engine_on   = 1'b0;
    chk_gap     = 1'b0;
    sensor_mask = 4'b0110;
    enable      = 1'b1;
    wait_starts(start_cnt + 1, 100);
    saved_res   = res_cnt;
    saved_start = start_cnt;
`ifdef HC_SR04_SCHEDULER_TIMEOUT_EN
    wait_results(saved_res + 1, 200);
    check("timeout_latency", 64'(last_res_cyc - last_start_cyc), 64'(TMO + 1));
    check("timeout_code", 64'(distances[prev_sel*W +: W]), 64'hFFF);
    check("timeout_valid", 64'(valid[prev_sel]), 64'd1);
`else
    repeat (1100) @(posedge clk);
    #1;
    check("no_watchdog_results", 64'(res_cnt), 64'(saved_res));
    check("no_watchdog_starts", 64'(start_cnt), 64'(saved_start));
    eng_trig = 1'b1;
    #1 check("no_watchdog_in_wait", 64'(trig), 64'(4'(1 << prev_sel)));
    eng_trig  = 1'b0;
    kick_dist = 12'h5A5;
    kick      = 1'b1;
    wait_results(saved_res + 1, 20);
`endif

    wait_starts(start_cnt + 1, 100);
    eng_trig = 1'b1;
    #1 check("pre_reset_trig", 64'(trig), 64'(4'(1 << prev_sel)));
    rst_n = 1'b0;
    #1;
    check("async_rst_trig", 64'(trig), 64'd0);
    check("async_rst_valid", 64'(valid), 64'd0);
    check("async_rst_distances", 64'(distances), 64'd0);
    eng_trig = 1'b0;
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
